// File: rtl/button_event_pkg.sv
// Shared event codes and per-channel FSM state encoding for the button event arbiter.
package button_event_pkg;

  localparam logic [1:0] EV_PRESS   = 2'b00;
  localparam logic [1:0] EV_RELEASE = 2'b01;
  localparam logic [1:0] EV_LONG    = 2'b10;
  localparam logic [1:0] EV_REPEAT  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PRESSED   = 2'd1,
    ST_LONG_HELD = 2'd2
  } fsm_state_t;

endpackage

// File: rtl/button_event_fsm.sv
// One button channel: edge detect, hold counter, event FSM, 1-deep pending slot and sticky overflow.
module button_event_fsm
  import button_event_pkg::*;
#(
  parameter int CNT_WIDTH     = 16,
  parameter int LONG_CYCLES   = 1000,
  parameter int REPEAT_CYCLES = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       btn,
  input  logic       grant,
  input  logic       ovf_clr,
  output logic       pend_valid,
  output logic [1:0] pend_code,
  output logic       ovf
);

  localparam logic [CNT_WIDTH-1:0] LONG_LAST   = CNT_WIDTH'(LONG_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] REPEAT_LAST = CNT_WIDTH'(REPEAT_CYCLES - 1);

  fsm_state_t           state, state_d;
  logic [CNT_WIDTH-1:0] cnt, cnt_d;
  logic                 lvl_q;
  logic                 rise, fall;
  logic                 raise;
  logic [1:0]           raise_code;

  assign rise = btn & ~lvl_q;
  assign fall = ~btn & lvl_q;

  // A falling edge is tested first so it always pre-empts a LONG/REPEAT due in the same cycle.
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    raise      = 1'b0;
    raise_code = EV_PRESS;
    if (!enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rise) begin
            state_d    = ST_PRESSED;
            cnt_d      = '0;
            raise      = 1'b1;
            raise_code = EV_PRESS;
          end
        end
        ST_PRESSED: begin
          if (fall) begin
            state_d    = ST_IDLE;
            cnt_d      = '0;
            raise      = 1'b1;
            raise_code = EV_RELEASE;
          end else if (btn) begin
            if (cnt == LONG_LAST) begin
              state_d    = ST_LONG_HELD;
              cnt_d      = '0;
              raise      = 1'b1;
              raise_code = EV_LONG;
            end else begin
              cnt_d = cnt + 1'b1;
            end
          end
        end
        ST_LONG_HELD: begin
          if (fall) begin
            state_d    = ST_IDLE;
            cnt_d      = '0;
            raise      = 1'b1;
            raise_code = EV_RELEASE;
          end else if (btn) begin
            if (cnt == REPEAT_LAST) begin
              cnt_d      = '0;
              raise      = 1'b1;
              raise_code = EV_REPEAT;
            end else begin
              cnt_d = cnt + 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      lvl_q      <= 1'b0;
      pend_valid <= 1'b0;
      pend_code  <= EV_PRESS;
      ovf        <= 1'b0;
    end else begin
      // Held at 0 while disabled so a button still down at re-enable yields a fresh PRESS.
      lvl_q <= enable ? btn : 1'b0;
      state <= state_d;
      cnt   <= cnt_d;
      if (raise && (!pend_valid || grant)) begin
        pend_valid <= 1'b1;
        pend_code  <= raise_code;
      end else if (grant) begin
        pend_valid <= 1'b0;
      end
      if (raise && pend_valid && !grant) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/button_event_arbiter.sv
// N button channels feeding a round-robin arbiter onto a single registered valid/ready event stream.
module button_event_arbiter
  import button_event_pkg::*;
#(
  parameter int N             = 4,
  parameter int CNT_WIDTH     = 16,
  parameter int LONG_CYCLES   = 1000,
  parameter int REPEAT_CYCLES = 250,
  localparam int CW           = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic [N-1:0]  btn_lvl,
  output logic          ev_valid,
  input  logic          ev_ready,
  output logic [CW-1:0] ev_chan,
  output logic [1:0]    ev_code,
  output logic [N-1:0]  ovf,
  input  logic          ovf_clr
);

  logic [N-1:0]      pend_valid;
  logic [N-1:0][1:0] pend_code;
  logic [N-1:0]      grant;
  logic [CW-1:0]     rr_ptr, gnt_idx, rr_next;
  logic              found, load;

  assign load = ~ev_valid | ev_ready;

  for (genvar i = 0; i < N; i++) begin : g_ch
    button_event_fsm #(
      .CNT_WIDTH    (CNT_WIDTH),
      .LONG_CYCLES  (LONG_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_fsm (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (enable),
      .btn       (btn_lvl[i]),
      .grant     (grant[i]),
      .ovf_clr   (ovf_clr),
      .pend_valid(pend_valid[i]),
      .pend_code (pend_code[i]),
      .ovf       (ovf[i])
    );
  end

  // Wrap is done by subtraction rather than modulo so N need not be a power of two.
  always_comb begin
    logic [CW:0] cand;
    found   = 1'b0;
    gnt_idx = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = {1'b0, rr_ptr} + (CW+1)'(k);
      if (cand >= (CW+1)'(N)) cand = cand - (CW+1)'(N);
      if (!found && pend_valid[cand[CW-1:0]]) begin
        found   = 1'b1;
        gnt_idx = cand[CW-1:0];
      end
    end
    grant = '0;
    if (load && found) grant[gnt_idx] = 1'b1;
    rr_next = (gnt_idx == CW'(N - 1)) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ev_valid <= 1'b0;
      ev_chan  <= '0;
      ev_code  <= EV_PRESS;
      rr_ptr   <= '0;
    end else if (load) begin
      if (found) begin
        ev_valid <= 1'b1;
        ev_chan  <= gnt_idx;
        ev_code  <= pend_code[gnt_idx];
        rr_ptr   <= rr_next;
      end else begin
        ev_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/button_event_arbiter.md
Name: button_event_arbiter

Overview:
- Converts N debounced button levels into discrete events: PRESS, RELEASE, LONG (long-press) and REPEAT (auto-repeat while held).
- Each channel runs its own event FSM with a 1-deep pending slot.
- A round-robin arbiter serialises pending events onto one valid/ready event stream for the command/UI sequencer.
- Sits directly downstream of the per-button debouncers.

Parameters:
- N, 4, number of button channels (2..16).
- CNT_WIDTH, 16, width of each per-channel hold counter.
- LONG_CYCLES, 1000, held cycles after PRESS before LONG fires (2..2^CNT_WIDTH-1).
- REPEAT_CYCLES, 250, cycles between successive REPEAT events after LONG (1..2^CNT_WIDTH-1).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- enable  in  1  1 = event detection active; 0 = FSMs forced to IDLE, no new events
- btn_lvl  in  N  debounced button levels, 1 = pressed
- ev_valid  out  1  event available
- ev_ready  in  1  consumer accepts event when ev_valid & ev_ready
- ev_chan  out  $clog2(N) (min 1)  channel index of the current event
- ev_code  out  2  00 PRESS, 01 RELEASE, 10 LONG, 11 REPEAT
- ovf  out  N  sticky per-channel overflow (event dropped)
- ovf_clr  in  1  synchronous clear of all ovf bits

Behaviour:
- Reset: all FSMs IDLE, lvl_q=0, counters=0, pending=0, rr_ptr=0, ev_valid=0, ev_chan=0, ev_code=0, ovf=0. Reset mid-operation discards all pending and output events immediately.
- btn_lvl registered once (lvl_q); edges are lvl_q vs btn_lvl.
- Per-channel FSM:
  - IDLE: rising edge -> PRESSED, cnt=0, raise PRESS.
  - PRESSED: level high -> cnt++. When cnt==LONG_CYCLES-1 -> LONG_HELD, cnt=0, raise LONG. Falling edge -> IDLE, raise RELEASE.
  - LONG_HELD: level high -> cnt++. When cnt==REPEAT_CYCLES-1 -> cnt=0, raise REPEAT. Falling edge -> IDLE, raise RELEASE.
- A falling edge overrides any LONG/REPEAT due in the same cycle; only RELEASE is raised.
- Counter never wraps: thresholds are reached before overflow by parameter constraint.
- Pending slot per channel (valid bit + 2-bit code):
  - Raised event with slot empty, or slot being granted this cycle -> stored.
  - Raised event with slot full and not granted this cycle -> new event dropped, old kept, ovf[i] set.
- Arbiter / output register:
  - Load condition: ev_valid==0, or ev_valid & ev_ready.
  - On load, the first pending channel searching from rr_ptr upward (wrapping) is granted, copied to ev_chan/ev_code, and its slot cleared.
  - ev_valid = 1 if any slot was pending, else 0.
  - rr_ptr = granted+1 mod N.
  - Load with no pending slot -> ev_valid=0, rr_ptr unchanged.
- ev_chan/ev_code are held stable while ev_valid & !ev_ready.
- Latency: rising btn_lvl at edge t -> PRESS pending after edge t+1 -> ev_valid high after edge t+2 (output idle, ready high).
- Throughput: one event per cycle with ev_ready held high.
- enable=0: FSMs and counters go to IDLE/0, no new events raised. Already-pending and output events still drain. Re-enable with button held -> PRESS on next cycle; lvl_q compared against 0 while disabled.
- ovf_clr and a same-cycle overflow -> ovf bit ends 1 (set wins).

Decomposition:
- Package button_event_pkg:
  - ev_code localparams EV_PRESS=2'b00, EV_RELEASE=2'b01, EV_LONG=2'b10, EV_REPEAT=2'b11.
  - FSM state encoding ST_IDLE, ST_PRESSED, ST_LONG_HELD.
- Sub-module button_event_fsm, instantiated N times via generate: level register, hold counter, FSM, pending slot, overflow bit. Inputs: grant/clear. Outputs: pend_valid, pend_code.
- Round-robin arbiter and output register stay in the top.

Test Plan (N=4, LONG_CYCLES=8, REPEAT_CYCLES=4 unless stated):
- Press ch1 for 3 cycles, ev_ready=1 -> PRESS(ch1) valid 2 cycles after rise; RELEASE(ch1) 2 cycles after fall; no LONG.
- Hold ch2 for 20 cycles -> PRESS, LONG 8 cycles after PRESS, REPEAT every 4 cycles (2 REPEATs), then RELEASE; ev_code 00,10,11,11,01.
- Rise ch0–ch3 in the same cycle, ev_ready=1 -> PRESS on ch0,1,2,3 in consecutive cycles. Repeat with rr_ptr=2 -> order 2,3,0,1.
- ev_ready=0, ch3 pressed/released/pressed -> output holds PRESS(ch3) stable, slot holds RELEASE, second PRESS dropped, ovf[3]=1. Assert ev_ready -> PRESS then RELEASE delivered. ovf_clr -> ovf=0.
- Hold ch1, deassert enable mid-PRESSED -> no LONG. Reassert enable with button still held -> new PRESS(ch1).
- Assert rst_n low while ev_valid=1 and slots pending -> all outputs 0 immediately; no stale event after release of reset.
